// File: rtl/sram_array_arbiter.sv
// Init sequencer and read/write arbiter for one 1R1W SRAM macro with a registered read address.
// Latency: writes pass through combinationally; a read response appears one cycle after its grant.
// Backpressure: w_ready/r_ready stay low for the whole init sweep and in a flush cycle; reads are round-robin.
//
// Ports: clock/reset (async, active-high); flush_req and init_done control and report the init sweep;
// w_* is the single write client; r_valid/r_ready/r_addr0/r_addr1 are the two read clients;
// rsp_valid/rsp_data return read data; mem_* drive the macro's pins, and mem_rdata comes back from it.
module sram_array_arbiter #(
  parameter int                ADDR_W     = 9,
  parameter int                DATA_W     = 16,
  parameter int                MASK_W     = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_req,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [1:0]        r_valid,
  output logic [1:0]        r_ready,
  input  logic [ADDR_W-1:0] r_addr0,
  input  logic [ADDR_W-1:0] r_addr1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [1:0]        rsp_valid_q;
  logic [1:0]        grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      // A grant issued in the last RUN cycle still gets its response, even if INIT follows.
      rsp_valid_q <= grant;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    grant     = 2'b00;
    w_ready   = 1'b0;
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_ren   = 1'b0;
    mem_raddr = '0;
    case (state_q)
      ST_INIT: begin
        mem_wen   = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VALUE;
        mem_wmask = '1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          w_ready   = 1'b1;
          mem_wen   = w_valid;
          mem_waddr = w_addr;
          mem_wdata = w_data;
          mem_wmask = w_mask;
          case (r_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
          endcase
          // The pointer names the client preferred on the next conflict: the one not just served.
          if (grant[0]) begin
            rr_ptr_d = 1'b1;
          end else if (grant[1]) begin
            rr_ptr_d = 1'b0;
          end
          mem_ren   = |grant;
          if (grant[1]) begin
            mem_raddr = r_addr1;
          end else if (grant[0]) begin
            mem_raddr = r_addr0;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign r_ready   = grant;
  assign init_done = (state_q == ST_RUN);
  assign rsp_valid = rsp_valid_q;
  // Gate the data so rsp_data stays zero outside a response.
  assign rsp_data  = (|rsp_valid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_array_arbiter.sv
module tb_sram_array_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush_req = 1'b0;
  logic        init_done;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [8:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic [7:0]  w_mask = '0;
  logic [1:0]  r_valid = 2'b00;
  logic [1:0]  r_ready;
  logic [8:0]  r_addr0 = '0;
  logic [8:0]  r_addr1 = '0;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        mem_wen;
  logic [8:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ren;
  logic [8:0]  mem_raddr;
  logic [15:0] mem_rdata;

  always #5 clock = ~clock;

  sram_array_arbiter dut (
    .clock(clock), .reset(reset), .flush_req(flush_req), .init_done(init_done),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr0(r_addr0), .r_addr1(r_addr1),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  // Behavioural 512x16 macro: 2-bit mask slices, registered read address, write-then-read at the edge.
  logic [15:0] macro_mem [512];
  logic [8:0]  macro_raddr_q = '0;
  always @(posedge clock) begin
    if (mem_wen) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_wmask[b]) macro_mem[mem_waddr][2*b +: 2] <= mem_wdata[2*b +: 2];
      end
    end
    if (mem_ren) macro_raddr_q <= mem_raddr;
  end
  assign mem_rdata = macro_mem[macro_raddr_q];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [1:0]  vld;
    logic [15:0] dat;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] ref_mem [512];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    flush_req = 1'b0;
    w_valid   = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    w_mask    = '0;
    r_valid   = 2'b00;
    r_addr0   = '0;
    r_addr1   = '0;
  endtask

  task automatic ref_write(input logic [8:0] a, input logic [15:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++) begin
      if (m[b]) ref_mem[a][2*b +: 2] = d[2*b +: 2];
    end
  endtask

  task automatic ref_clear();
    for (int a = 0; a < 512; a++) ref_mem[a] = 16'h0000;
  endtask

  // Call when driving a read expected to be granted this cycle.
  task automatic push_rsp(input logic [1:0] vld, input logic [15:0] dat);
    exp_t e;
    e.due = cyc + 1;
    e.vld = vld;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL rsp_missing: no response at cycle %0d, required vld=%b data=%h", e.due, e.vld, e.dat);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        n_chk++;
        if (rsp_valid !== e.vld || rsp_data !== e.dat) begin
          n_fail++;
          $display("FAIL rsp: cycle %0d got vld=%b data=%h, required vld=%b data=%h",
                   cyc, rsp_valid, rsp_data, e.vld, e.dat);
        end
      end else if (rsp_valid !== 2'b00) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: cycle %0d got vld=%b, required 00", cyc, rsp_valid);
      end
    end
  endtask

  // Starts in the first INIT cycle; returns INIT cycle count, cycles with a ready high,
  // and cycles whose macro write pins differ from the sweep pattern.
  task automatic run_sweep(output int cycles, output int ready_seen, output int pin_err);
    cycles = 0;
    ready_seen = 0;
    pin_err = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (init_done === 1'b1) break;
      if (w_ready !== 1'b0 || r_ready !== 2'b00) ready_seen++;
      if (mem_wen !== 1'b1 || mem_waddr !== cycles[8:0] || mem_wdata !== 16'h0000 ||
          mem_wmask !== 8'hFF || mem_ren !== 1'b0) pin_err++;
      cycles++;
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic check_sweep(input string name);
    int cycles, ready_seen, pin_err;
    run_sweep(cycles, ready_seen, pin_err);
    n_chk++;
    if (cycles != 512) begin
      n_fail++;
      $display("FAIL %s_length: got %0d cycles, required 512", name, cycles);
    end
    n_chk++;
    if (ready_seen != 0) begin
      n_fail++;
      $display("FAIL %s_ready: ready high in %0d sweep cycles, required 0", name, ready_seen);
    end
    n_chk++;
    if (pin_err != 0) begin
      n_fail++;
      $display("FAIL %s_pins: %0d cycles with wrong macro write pins, required 0", name, pin_err);
    end
  endtask

  task automatic test_readback(input int client);
    int bad = 0;
    logic [1:0] oh;
    oh = (client == 0) ? 2'b01 : 2'b10;
    for (int a = 0; a < 512; a++) begin
      r_valid = oh;
      r_addr0 = a[8:0];
      r_addr1 = a[8:0];
      push_rsp(oh, ref_mem[a]);
      @(negedge clock);
      if (r_ready !== oh || mem_ren !== 1'b1 || mem_raddr !== a[8:0]) bad++;
      step();
    end
    drive_idle();
    step();
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL readback_grant_c%0d: %0d cycles with wrong grant/read pins, required 0", client, bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    w_valid = 1'b1;
    r_valid = 2'b11;
    repeat (3) step();
    @(negedge clock);
    n_chk++;
    if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b required 0", init_done); end
    n_chk++;
    if (r_ready !== 2'b00 || w_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got r=%b w=%b required 00/0", r_ready, w_ready);
    end
    n_chk++;
    if (mem_wen !== 1'b1 || mem_waddr !== 9'h000 || mem_ren !== 1'b0) begin
      n_fail++; $display("FAIL reset_pins: got wen=%b waddr=%h ren=%b required 1/000/0", mem_wen, mem_waddr, mem_ren);
    end
    n_chk++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 00", rsp_valid); end
    step();
    reset = 1'b0;
    check_sweep("init_sweep");
    ref_clear();
    test_readback(0);
  endtask

  task automatic test_write_read();
    w_valid = 1'b1;
    w_addr  = 9'h1A5;
    w_data  = 16'hBEEF;
    w_mask  = 8'hFF;
    ref_write(9'h1A5, 16'hBEEF, 8'hFF);
    @(negedge clock);
    n_chk++;
    if (w_ready !== 1'b1 || mem_wen !== 1'b1 || mem_waddr !== 9'h1A5 ||
        mem_wdata !== 16'hBEEF || mem_wmask !== 8'hFF) begin
      n_fail++;
      $display("FAIL write_pass: got rdy=%b wen=%b a=%h d=%h m=%h required 1/1/1a5/beef/ff",
               w_ready, mem_wen, mem_waddr, mem_wdata, mem_wmask);
    end
    step();
    drive_idle();
    r_valid = 2'b01;
    r_addr0 = 9'h1A5;
    push_rsp(2'b01, 16'hBEEF);
    @(negedge clock);
    n_chk++;
    if (r_ready !== 2'b01 || mem_ren !== 1'b1 || mem_raddr !== 9'h1A5 || mem_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL read_grant: got rdy=%b ren=%b raddr=%h wen=%b required 01/1/1a5/0",
               r_ready, mem_ren, mem_raddr, mem_wen);
    end
    step();
    drive_idle();
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1;
      w_mask  = 8'hFF;
      w_addr  = 9'h010 + 9'(i);
      w_data  = 16'h1000 + 16'(i);
      ref_write(w_addr, w_data, w_mask);
      step();
      w_addr  = 9'h020 + 9'(i);
      w_data  = 16'h2000 + 16'(i);
      ref_write(w_addr, w_data, w_mask);
      step();
    end
    drive_idle();
    // A lone client-1 read leaves client 0 preferred.
    r_valid = 2'b10;
    r_addr1 = 9'h1A5;
    push_rsp(2'b10, ref_mem[9'h1A5]);
    step();
    for (int i = 0; i < 4; i++) begin
      r_valid = 2'b11;
      r_addr0 = 9'h010 + 9'(i);
      r_addr1 = 9'h020 + 9'(i);
      push_rsp(exp_gnt[i], exp_gnt[i][1] ? ref_mem[r_addr1] : ref_mem[r_addr0]);
      @(negedge clock);
      n_chk++;
      if (r_ready !== exp_gnt[i]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b required %b", i, r_ready, exp_gnt[i]);
      end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_same_addr();
    w_valid = 1'b1;
    w_addr  = 9'h0AA;
    w_data  = 16'hFFFF;
    w_mask  = 8'hFF;
    ref_write(9'h0AA, 16'hFFFF, 8'hFF);
    step();
    w_data  = 16'h0000;
    w_mask  = 8'h0F;
    ref_write(9'h0AA, 16'h0000, 8'h0F);
    r_valid = 2'b10;
    r_addr1 = 9'h0AA;
    push_rsp(2'b10, 16'hFF00);
    @(negedge clock);
    n_chk++;
    if (r_ready !== 2'b10 || mem_wen !== 1'b1 || mem_wmask !== 8'h0F) begin
      n_fail++;
      $display("FAIL same_addr_fire: got rdy=%b wen=%b mask=%h required 10/1/0f", r_ready, mem_wen, mem_wmask);
    end
    step();
    drive_idle();
    step();
  endtask

  task automatic test_flush();
    r_valid = 2'b01;
    r_addr0 = 9'h1A5;
    push_rsp(2'b01, ref_mem[9'h1A5]);
    step();
    // Pending response from the cycle above must still arrive during the flush cycle.
    flush_req = 1'b1;
    r_valid   = 2'b11;
    w_valid   = 1'b1;
    w_addr    = 9'h1A5;
    w_data    = 16'h1234;
    w_mask    = 8'hFF;
    @(negedge clock);
    n_chk++;
    if (r_ready !== 2'b00 || w_ready !== 1'b0 || mem_wen !== 1'b0 || mem_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_block: got rdy=%b wrdy=%b wen=%b ren=%b required 00/0/0/0",
               r_ready, w_ready, mem_wen, mem_ren);
    end
    step();
    flush_req = 1'b0;
    check_sweep("flush_sweep");
    ref_clear();
    test_readback(1);
  endtask

  task automatic test_reset_mid_sweep();
    flush_req = 1'b1;
    step();
    drive_idle();
    repeat (200) step();
    @(negedge clock);
    n_chk++;
    if (mem_waddr !== 9'd200 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_sweep_addr: got waddr=%0d done=%b required 200/0", mem_waddr, init_done);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (mem_waddr !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_sweep_reset_cnt: got waddr=%0d required 0", mem_waddr);
    end
    step();
    step();
    reset = 1'b0;
    check_sweep("reinit_sweep");
    ref_clear();
  endtask

  initial begin
    drive_idle();
    ref_clear();
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_write_read();
    test_round_robin();
    test_same_addr();
    test_flush();
    test_reset_mid_sweep();
    repeat (4) step();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
